// File: rtl/vga_board_pkg.sv
// Shared types and constants for the frame-synchronous board scheduler.
// Boards are 16 row-major 4-bit log2 tile codes; nibble 15 is top-left.
package vga_board_pkg;

    localparam int BOARD_W   = 64;
    localparam int TILE_W    = 4;
    localparam int NUM_TILES = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COMMIT
    } state_t;

    function automatic logic [TILE_W-1:0] tile(input logic [BOARD_W-1:0] board, input int i);
        return board[i*TILE_W +: TILE_W];
    endfunction

endpackage

// File: rtl/board_fifo2.sv
// Two-entry board FIFO between the game logic and the frame scheduler.
// Pushes into a full FIFO are ignored even if a pop happens the same cycle.
module board_fifo2
    import vga_board_pkg::*;
(
    input  logic               clk_65,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [BOARD_W-1:0] data,
    output logic [BOARD_W-1:0] head,
    output logic [1:0]         count,
    output logic               full
);

    logic [BOARD_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == 2'd2);
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk_65) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; the count alone decides which entries are
    // valid, so the data array maps onto plain registers without reset logic.
    always_ff @(posedge clk_65) begin
        if (push_ok) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/vga_board_scheduler.sv
// Commits buffered boards to the renderer only at frame boundaries, after a
// minimum hold time. Optional changed-tile highlight mask: define HL_MASK_EN.
module vga_board_scheduler
    import vga_board_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 4,
    parameter int unsigned HL_FRAMES   = 8
) (
    input  logic               clk_65,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               upd_valid,
    input  logic [BOARD_W-1:0] upd_board,
    output logic               upd_ready,
    output logic [BOARD_W-1:0] disp_board,
    output logic               commit,
    output logic [1:0]         pending,
    output logic [15:0]        hl_mask
);

    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BOARD_W-1:0] head;
    logic [1:0]         count;
    logic               full;
    logic               push;
    logic               pop;

    assign upd_ready = !full;
    assign push      = upd_valid && upd_ready;
    assign pop       = (state == S_COMMIT);
    assign pending   = count;

    board_fifo2 u_fifo (
        .clk_65 (clk_65),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .data   (upd_board),
        .head   (head),
        .count  (count),
        .full   (full)
    );

    // The commit decision looks at hold_cnt before this frame's decrement.
    always_ff @(posedge clk_65) begin
        if (!rst) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            disp_board <= '0;
            commit     <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (frame_start && hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_ONE;
            unique case (state)
                S_IDLE: begin
                    if (push) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (frame_start && hold_cnt == '0) state <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_board <= head;
                    commit     <= 1'b1;
                    hold_cnt   <= HOLD_LOAD;
                    state      <= (count > 2'd1 || push) ? S_ARMED : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HL_MASK_EN
    localparam int HL_W = (HL_FRAMES > 0) ? $clog2(HL_FRAMES + 1) : 1;
    localparam logic [HL_W-1:0] HL_LOAD = HL_W'(HL_FRAMES);
    localparam logic [HL_W-1:0] HL_ONE  = HL_W'(1);

    logic [HL_W-1:0]      hl_cnt;
    logic [NUM_TILES-1:0] diff;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        diff = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            diff[i] = (tile(head, i) != tile(disp_board, i));
        end
    end

    always_ff @(posedge clk_65) begin
        if (!rst) begin
            hl_cnt  <= '0;
            hl_mask <= '0;
        end else if (state == S_COMMIT) begin
            hl_cnt  <= HL_LOAD;
            hl_mask <= (HL_FRAMES == 0) ? '0 : diff;
        end else if (frame_start && hl_cnt != '0) begin
            hl_cnt <= hl_cnt - HL_ONE;
            if (hl_cnt == HL_ONE) hl_mask <= '0;
        end
    end
`else
    assign hl_mask = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_board_scheduler.sv
// Directed bench for vga_board_scheduler with HOLD_FRAMES=4, HL_FRAMES=2.
// Highlight expectations follow HL_MASK_EN; without it hl_mask must stay zero.
module tb_vga_board_scheduler;

`ifdef HL_MASK_EN
    localparam logic [15:0] HL_ON = 16'hFFFF;
`else
    localparam logic [15:0] HL_ON = 16'h0000;
`endif

    localparam logic [63:0] BRD_A = 64'h1000_0000_0000_0002;
    localparam logic [63:0] BRD_B = 64'h2000_0000_0000_0002;
    localparam logic [63:0] BRD_C = 64'h0000_0000_0000_0C00;
    localparam logic [63:0] BRD_D = 64'h0000_0000_00D0_0000;
    localparam logic [63:0] BRD_E = 64'hE000_0000_0000_0000;
    localparam logic [63:0] BRD_F = 64'h0000_0F00_0000_0000;
    localparam logic [63:0] BRD_G = 64'h0000_0000_0000_0070;
    localparam logic [63:0] BRD_H = 64'h1111_1111_1111_1111;
    localparam logic [63:0] BRD_I = 64'h2222_2222_2222_2222;
    localparam logic [63:0] BRD_J = 64'h0000_0000_0000_0011;

    logic        clk_65;
    logic        rst;
    logic        frame_start;
    logic        upd_valid;
    logic [63:0] upd_board;
    logic        upd_ready;
    logic [63:0] disp_board;
    logic        commit;
    logic [1:0]  pending;
    logic [15:0] hl_mask;

    int checks = 0;
    int errors = 0;

    vga_board_scheduler #(
        .HOLD_FRAMES (4),
        .HL_FRAMES   (2)
    ) dut (
        .clk_65      (clk_65),
        .rst         (rst),
        .frame_start (frame_start),
        .upd_valid   (upd_valid),
        .upd_board   (upd_board),
        .upd_ready   (upd_ready),
        .disp_board  (disp_board),
        .commit      (commit),
        .pending     (pending),
        .hl_mask     (hl_mask)
    );

    initial begin
        clk_65 = 1'b0;
        forever #8 clk_65 = ~clk_65;
    end

    initial begin
        #500_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_65);
        #1;
    endtask

    task automatic push_board(input logic [63:0] b);
        upd_valid = 1'b1;
        upd_board = b;
        tick();
        upd_valid = 1'b0;
    endtask

    // Leaves the bench in the cycle where a commit triggered by this pulse is visible.
    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic hold_frames(input int n, input logic [63:0] shown);
        for (int i = 0; i < n; i++) begin
            frame();
            check("hold_commit", {63'd0, commit}, 64'd0);
            check("hold_disp", disp_board, shown);
        end
    endtask

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        upd_valid   = 1'b0;
        upd_board   = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        check("rst_disp", disp_board, 64'd0);
        check("rst_commit", {63'd0, commit}, 64'd0);
        check("rst_pending", {62'd0, pending}, 64'd0);
        check("rst_ready", {63'd0, upd_ready}, 64'd1);
        check("rst_hl", {48'd0, hl_mask}, 64'd0);

        // First board commits two cycles after the frame pulse.
        push_board(BRD_A);
        check("a_pending", {62'd0, pending}, 64'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("a_lat1_commit", {63'd0, commit}, 64'd0);
        check("a_lat1_disp", disp_board, 64'd0);
        tick();
        check("a_commit", {63'd0, commit}, 64'd1);
        check("a_disp", disp_board, BRD_A);
        check("a_pending0", {62'd0, pending}, 64'd0);
        check("a_hl", {48'd0, hl_mask}, {48'd0, 16'h8001 & HL_ON});

        // B waits four boundaries; highlight clears on the second.
        push_board(BRD_B);
        check("b_commit_pulse_gone", {63'd0, commit}, 64'd0);
        hold_frames(1, BRD_A);
        check("hl_after_1", {48'd0, hl_mask}, {48'd0, 16'h8001 & HL_ON});
        hold_frames(1, BRD_A);
        check("hl_after_2", {48'd0, hl_mask}, 64'd0);
        hold_frames(2, BRD_A);
        frame();
        check("b_commit", {63'd0, commit}, 64'd1);
        check("b_disp", disp_board, BRD_B);
        check("b_hl", {48'd0, hl_mask}, {48'd0, 16'h8000 & HL_ON});

        // Three back-to-back boards: the third is held off until a slot frees.
        upd_valid = 1'b1;
        upd_board = BRD_C;
        tick();
        upd_board = BRD_D;
        tick();
        upd_board = BRD_E;
        check("full_pending", {62'd0, pending}, 64'd2);
        check("full_ready", {63'd0, upd_ready}, 64'd0);
        hold_frames(4, BRD_B);
        check("full_held", {62'd0, pending}, 64'd2);
        frame();
        check("c_commit", {63'd0, commit}, 64'd1);
        check("c_disp", disp_board, BRD_C);
        check("c_pending", {62'd0, pending}, 64'd1);
        check("c_ready", {63'd0, upd_ready}, 64'd1);
        tick();
        upd_valid = 1'b0;
        check("e_accepted", {62'd0, pending}, 64'd2);
        hold_frames(4, BRD_C);
        frame();
        check("d_disp", disp_board, BRD_D);
        check("d_commit", {63'd0, commit}, 64'd1);
        hold_frames(4, BRD_D);
        frame();
        check("e_disp", disp_board, BRD_E);
        check("e_pending", {62'd0, pending}, 64'd0);

        // Push in the same cycle as the commit pop with one board buffered.
        push_board(BRD_F);
        hold_frames(4, BRD_E);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        upd_valid = 1'b1;
        upd_board = BRD_G;
        tick();
        upd_valid = 1'b0;
        check("f_commit", {63'd0, commit}, 64'd1);
        check("f_disp", disp_board, BRD_F);
        check("f_pending", {62'd0, pending}, 64'd1);
        hold_frames(4, BRD_F);
        frame();
        check("g_commit", {63'd0, commit}, 64'd1);
        check("g_disp", disp_board, BRD_G);
        check("g_pending", {62'd0, pending}, 64'd0);

        // Reset with two boards buffered mid-hold.
        push_board(BRD_H);
        push_board(BRD_I);
        hold_frames(1, BRD_G);
        check("pre_rst_pending", {62'd0, pending}, 64'd2);
        rst = 1'b0;
        tick();
        check("mid_rst_disp", disp_board, 64'd0);
        check("mid_rst_pending", {62'd0, pending}, 64'd0);
        check("mid_rst_ready", {63'd0, upd_ready}, 64'd1);
        check("mid_rst_hl", {48'd0, hl_mask}, 64'd0);
        rst = 1'b1;
        hold_frames(1, 64'd0);
        check("post_rst_pending", {62'd0, pending}, 64'd0);

        // Hold counter was cleared by reset, so the next board commits at once.
        push_board(BRD_J);
        frame();
        check("j_commit", {63'd0, commit}, 64'd1);
        check("j_disp", disp_board, BRD_J);
        check("j_hl", {48'd0, hl_mask}, {48'd0, 16'h0003 & HL_ON});

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_board_scheduler.md
# vga_board_scheduler

Frame-synchronous scheduler between the 2048 game logic and the VGA renderer. It accepts new 64-bit board states from the game FSM through a valid/ready handshake and buffers up to two of them. It commits each board to the renderer's board input only at a frame boundary, and only after the previous board has been shown for a minimum number of frames. This prevents tearing and makes every move visible.

## Interface
- HOLD_FRAMES, 4: minimum number of frame boundaries a committed board stays displayed before the next commit; 0 allows a commit at every boundary.
- HL_FRAMES, 8: number of frame boundaries the changed-tile highlight mask stays asserted (used only with HL_MASK_EN).
- clk_65  in  1  pixel clock, 65 MHz.
- rst  in  1  synchronous reset, active-low.
- frame_start  in  1  one-cycle pulse from the timing generator on the first line of vertical blanking.
- upd_valid  in  1  game logic presents a board on upd_board.
- upd_board  in  64  board; nibble 15 is [63:60] and is top-left, row-major, values are 4-bit log2 tile codes, 0 means empty.
- upd_ready  out  1  buffer can accept a board.
- disp_board  out  64  board driven to the renderer's board input.
- commit  out  1  one-cycle pulse in the first cycle disp_board holds a new value.
- pending  out  2  number of buffered boards, 0..2.
- hl_mask  out  16  bit i set means nibble i changed at the last commit.

## Operation
- The buffer is a 2-entry FIFO.
  - upd_ready = (pending != 2), combinational from the count.
  - A push occurs on any cycle with upd_valid && upd_ready.
  - A push and a pop in the same cycle leaves pending unchanged.
  - No push is accepted while full, even if a pop occurs that cycle.
- hold_cnt is a down-counter of width $clog2(HOLD_FRAMES+1).
  - It decrements on each frame_start while non-zero.
  - It is loaded with HOLD_FRAMES on every commit.
- The FSM has three states.
  - S_IDLE: pending == 0. A push moves the FSM to S_ARMED.
  - S_ARMED: pending > 0. Sampling frame_start=1 while hold_cnt == 0 moves the FSM to S_COMMIT. frame_start while hold_cnt > 0 only decrements hold_cnt; the FSM stays in S_ARMED.
  - S_COMMIT: lasts one cycle. It pops the FIFO head into disp_board and loads hold_cnt. It then returns to S_ARMED if a board remains after the pop (including a same-cycle push), else to S_IDLE.
- A frame_start sampled in S_COMMIT cannot trigger a second commit.
- Boards are never dropped or reordered. With two boards queued, one commits per eligible frame.
- The commit condition tests hold_cnt before this frame's decrement. For example, HOLD_FRAMES=1 allows commits on every second boundary.

## Timing
- The commit decision is made at the edge sampling frame_start. disp_board and commit update at the following edge, so they are valid 2 cycles after frame_start rises. This lies deep inside vertical blanking, so no visible line is affected.
- disp_board is stable for the full frame; it changes only at commit.
- upd_ready reflects pending in the same cycle. A push is visible in pending at the next edge.
- Reset values:
  - disp_board = 64'h0 (empty board)
  - commit = 0
  - pending = 0, hence upd_ready = 1
  - hl_mask = 0
  - hold_cnt = 0
  - FSM in S_IDLE
- A reset mid-operation discards buffered boards. The renderer shows the empty board from the next frame on.

## Configuration
- HL_MASK_EN defined:
  - On commit, hl_mask[i] is loaded with (new nibble i != old disp_board nibble i), in the same cycle as commit.
  - hl_cnt is loaded with HL_FRAMES and decrements per frame_start.
  - hl_mask clears at the edge where hl_cnt goes from 1 to 0.
  - A new commit reloads both the mask and the counter.
  - HL_FRAMES=0 means the mask is never set.
- HL_MASK_EN undefined: hl_mask is tied to 16'h0000 and no hl_cnt logic exists. The port list is unchanged.

## Structure
- Package vga_board_pkg:
  - BOARD_W=64, TILE_W=4, NUM_TILES=16
  - the state enum {S_IDLE, S_ARMED, S_COMMIT}
  - function tile(board, i) returning nibble i
- Sub-module board_fifo2: a 2-entry, 64-bit FIFO with push/pop/count/head outputs. The scheduler contains the FSM, hold counter and highlight logic.

## Test plan
- Push A=64'h1000_0000_0000_0002 from reset, then pulse frame_start: disp_board=A and commit=1 exactly 2 cycles after the pulse, pending returns to 0.
- HOLD_FRAMES=4: push A, commit, then push B. B commits only on the 5th frame_start after A's commit; earlier pulses leave disp_board=A.
- Push three boards back-to-back: upd_ready drops after the second push and the third is held off. It is accepted the cycle after the next commit. Boards commit in order A, B, C.
- Push in the same cycle as the S_COMMIT pop with pending=1: pending stays 1 and the FSM returns to S_ARMED.
- Assert rst low with pending=2 mid-hold: next cycle disp_board=0, pending=0, upd_ready=1. A following frame_start produces no commit.
- HL_MASK_EN, HL_FRAMES=2: commit a board differing in nibbles 15 and 0. hl_mask=16'h8001 with commit, and it clears at the 2nd subsequent frame_start.
